// File: rtl/csr_write_buffer_if.sv
// Port bundle for the CSR write buffer: enqueue, commit/flush, CSR-file write and read bypass.
// The buffer uses the slave modport; the pipeline or testbench drives the master side.
interface csr_write_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROBW  = 6
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            enq_valid;
  logic            enq_ready;
  logic [ROBW-1:0] enq_rob_id;
  logic [13:0]     enq_addr;
  logic [31:0]     enq_data;
  logic [31:0]     enq_mask;

  logic            commit_valid;
  logic [ROBW-1:0] commit_rob_id;
  logic            flush;

  logic            csr_wable;
  logic [13:0]     csr_waddr;
  logic [31:0]     csr_wdata;
  logic [31:0]     csr_wmask;

  logic [13:0]     rd_addr;
  logic            rd_hit;
  logic [31:0]     rd_data;
  logic [31:0]     rd_mask;

  logic [CntW-1:0] count;

  modport master (
    output enq_valid, enq_rob_id, enq_addr, enq_data, enq_mask,
    output commit_valid, commit_rob_id, flush, rd_addr,
    input  enq_ready, csr_wable, csr_waddr, csr_wdata, csr_wmask,
    input  rd_hit, rd_data, rd_mask, count
  );

  modport slave (
    input  enq_valid, enq_rob_id, enq_addr, enq_data, enq_mask,
    input  commit_valid, commit_rob_id, flush, rd_addr,
    output enq_ready, csr_wable, csr_waddr, csr_wdata, csr_wmask,
    output rd_hit, rd_data, rd_mask, count
  );
endinterface

// File: rtl/csr_write_buffer.sv
// Holds speculative CSR writes until their instruction retires, then issues them to the CSR
// file one cycle after commit; younger pending writes are bypassed to speculative reads.
module csr_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROBW  = 6
) (
  input logic             clk,
  input logic             rst_n,
  csr_write_buffer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0]   head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0] head_idx, tail_idx, scan_idx;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [ROBW-1:0] rob_q  [DEPTH];
  logic [13:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     mask_q [DEPTH];

  logic        csr_wable_q;
  logic [13:0] csr_waddr_q;
  logic [31:0] csr_wdata_q, csr_wmask_q;

  logic [PtrW:0] count;
  logic          enq_fire, commit_fire;

  assign head_idx = head_q[PtrW-1:0];
  assign tail_idx = tail_q[PtrW-1:0];
  assign count    = tail_q - head_q;

  // Readiness uses the registered count only: a same-cycle commit never frees a slot early.
  assign bus.enq_ready = (count < (PtrW + 1)'(DEPTH)) && !bus.flush;
  assign enq_fire      = bus.enq_valid && bus.enq_ready;
  assign commit_fire   = bus.commit_valid && (count != '0) &&
                         (bus.commit_rob_id == rob_q[head_idx]);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
    end else begin
      if (commit_fire) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + 1'b1;
      end
      if (enq_fire) begin
        valid_d[tail_idx] = 1'b1;
        tail_d            = tail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i]  <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      if (enq_fire) begin
        rob_q[tail_idx]  <= bus.enq_rob_id;
        addr_q[tail_idx] <= bus.enq_addr;
        data_q[tail_idx] <= bus.enq_data;
        mask_q[tail_idx] <= bus.enq_mask;
      end
    end
  end

  // A commit is older than any flush in the same cycle, so its write still goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_wable_q <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      csr_wmask_q <= '0;
    end else begin
      csr_wable_q <= commit_fire;
      if (commit_fire) begin
        csr_waddr_q <= addr_q[head_idx];
        csr_wdata_q <= data_q[head_idx];
        csr_wmask_q <= mask_q[head_idx];
      end
    end
  end

  assign bus.csr_wable = csr_wable_q;
  assign bus.csr_waddr = csr_waddr_q;
  assign bus.csr_wdata = csr_wdata_q;
  assign bus.csr_wmask = csr_wmask_q;
  assign bus.count     = count;

  // Scan oldest to youngest so the last match (the youngest) wins.
  always_comb begin
    bus.rd_hit  = 1'b0;
    bus.rd_data = '0;
    bus.rd_mask = '0;
    scan_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_idx + PtrW'(i);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == bus.rd_addr)) begin
        bus.rd_hit  = 1'b1;
        bus.rd_data = data_q[scan_idx];
        bus.rd_mask = mask_q[scan_idx];
      end
    end
  end
endmodule

// File: tb/tb_csr_write_buffer.sv
// Randomized and directed bench for csr_write_buffer against a queue-based reference model.
module tb_csr_write_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ROBW  = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_write_buffer_if #(.DEPTH(DEPTH), .ROBW(ROBW)) bus ();

  csr_write_buffer #(.DEPTH(DEPTH), .ROBW(ROBW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [ROBW-1:0] rob;
    logic [13:0]     addr;
    logic [31:0]     data;
    logic [31:0]     mask;
  } ent_t;

  ent_t model_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, then check the registered write.
  task automatic step(input bit ev, input logic [ROBW-1:0] rob, input logic [13:0] addr,
                      input logic [31:0] data, input logic [31:0] mask, input bit cv,
                      input logic [ROBW-1:0] crob, input bit fl, input logic [13:0] ra);
    bit          exp_ready, fire, hit;
    logic [31:0] hd, hm;
    ent_t        w;
    @(negedge clk);
    bus.enq_valid     = ev;
    bus.enq_rob_id    = rob;
    bus.enq_addr      = addr;
    bus.enq_data      = data;
    bus.enq_mask      = mask;
    bus.commit_valid  = cv;
    bus.commit_rob_id = crob;
    bus.flush         = fl;
    bus.rd_addr       = ra;
    #1;
    exp_ready = (model_q.size() < DEPTH) && !fl;
    hit = 1'b0;
    hd  = '0;
    hm  = '0;
    foreach (model_q[i]) begin
      if (model_q[i].addr == ra) begin
        hit = 1'b1;
        hd  = model_q[i].data;
        hm  = model_q[i].mask;
      end
    end
    check("enq_ready", 64'(bus.enq_ready), 64'(exp_ready));
    check("count", 64'(bus.count), 64'(model_q.size()));
    check("rd_hit", 64'(bus.rd_hit), 64'(hit));
    check("rd_data", 64'(bus.rd_data), 64'(hd));
    check("rd_mask", 64'(bus.rd_mask), 64'(hm));
    fire = cv && (model_q.size() > 0) && (model_q[0].rob == crob);
    w    = '{rob: '0, addr: '0, data: '0, mask: '0};
    if (fire) w = model_q.pop_front();
    if (fl) model_q.delete();
    else if (ev && exp_ready) model_q.push_back('{rob: rob, addr: addr, data: data, mask: mask});
    @(posedge clk);
    #1;
    check("csr_wable", 64'(bus.csr_wable), 64'(fire));
    if (fire) begin
      check("csr_waddr", 64'(bus.csr_waddr), 64'(w.addr));
      check("csr_wdata", 64'(bus.csr_wdata), 64'(w.data));
      check("csr_wmask", 64'(bus.csr_wmask), 64'(w.mask));
    end
  endtask

  task automatic idle(input logic [13:0] ra);
    step(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, ra);
  endtask

  task automatic enq(input logic [ROBW-1:0] rob, input logic [13:0] addr, input logic [31:0] data);
    step(1'b1, rob, addr, data, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, 14'h0);
  endtask

  task automatic commit(input logic [ROBW-1:0] crob);
    step(1'b0, '0, '0, '0, '0, 1'b1, crob, 1'b0, 14'h0);
  endtask

  task automatic apply_reset(input logic [13:0] ra);
    @(negedge clk);
    bus.enq_valid    = 1'b0;
    bus.commit_valid = 1'b0;
    bus.flush        = 1'b0;
    bus.rd_addr      = ra;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_wable", 64'(bus.csr_wable), 64'd0);
    check("rst_waddr", 64'(bus.csr_waddr), 64'd0);
    check("rst_wdata", 64'(bus.csr_wdata), 64'd0);
    check("rst_wmask", 64'(bus.csr_wmask), 64'd0);
    check("rst_rd_hit", 64'(bus.rd_hit), 64'd0);
    model_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ROBW-1:0] crob;
    bus.enq_valid     = 1'b0;
    bus.enq_rob_id    = '0;
    bus.enq_addr      = '0;
    bus.enq_data      = '0;
    bus.enq_mask      = '0;
    bus.commit_valid  = 1'b0;
    bus.commit_rob_id = '0;
    bus.flush         = 1'b0;
    bus.rd_addr       = '0;
    apply_reset(14'h30);
    idle(14'h30);

    // Single write, commit, one-cycle latency.
    enq(6'd5, 14'h30, 32'hDEAD_BEEF);
    commit(6'd5);
    check("req033_data", 64'(bus.csr_wdata), 64'h0000_0000_DEAD_BEEF);
    idle(14'h30);

    // Fill, refuse on full despite same-cycle commit, then wrap.
    for (int i = 1; i <= 4; i++) enq(ROBW'(i), 14'h40 + 14'(i), 32'h100 + 32'(i));
    idle(14'h42);
    step(1'b1, 6'd9, 14'h49, 32'h999, 32'hF, 1'b1, 6'd1, 1'b0, 14'h41);
    check("req034_count3", 64'(bus.count), 64'd3);
    enq(6'd5, 14'h45, 32'h105);
    idle(14'h45);
    for (int i = 2; i <= 5; i++) commit(ROBW'(i));

    // Bypass returns the youngest of two matching writes.
    enq(6'd10, 14'h31, 32'h11);
    enq(6'd11, 14'h31, 32'h22);
    idle(14'h31);
    check("req035_hit", 64'(bus.rd_hit), 64'd1);
    check("req035_data", 64'(bus.rd_data), 64'h22);
    idle(14'h32);
    commit(6'd10);
    commit(6'd11);

    // Commit of a non-head ROB id is ignored.
    enq(6'd6, 14'h33, 32'h66);
    commit(6'd7);
    check("req036_count", 64'(bus.count), 64'd1);
    commit(6'd6);

    // Commit and flush in the same cycle.
    enq(6'd20, 14'h34, 32'hA0);
    enq(6'd21, 14'h35, 32'hA1);
    enq(6'd22, 14'h36, 32'hA2);
    step(1'b1, 6'd23, 14'h37, 32'hA3, 32'hFF, 1'b1, 6'd20, 1'b1, 14'h35);
    commit(6'd21);
    idle(14'h35);

    // Reset with entries pending.
    enq(6'd30, 14'h38, 32'hB0);
    enq(6'd31, 14'h39, 32'hB1);
    apply_reset(14'h38);
    idle(14'h38);
    commit(6'd30);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      crob = ROBW'($urandom);
      if ((model_q.size() > 0) && ($urandom_range(0, 99) < 60)) crob = model_q[0].rob;
      step($urandom_range(0, 99) < 60, ROBW'($urandom), 14'h30 + 14'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom_range(0, 99) < 50, crob, $urandom_range(0, 99) < 4,
           14'h30 + 14'($urandom_range(0, 4)));
      if (n == 300) apply_reset(14'h31);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/csr_write_buffer.md
CSR_WRITE_BUFFER -- requirements
Module: csr_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending CSR-write entries (power of two).
REQ-002 SHALL have parameter ROBW, default 6, ROB index width.
REQ-003 Clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 Rest  in  1  reset, asynchronous, active-low.
REQ-005 EnqValid  in  1  execute stage presents a csrwr/csrxchg write.
REQ-006 EnqReady  out  1  buffer accepts an entry this cycle.
REQ-007 EnqRobId  in  ROBW  ROB index of the writing instruction.
REQ-008 EnqAddr  in  14  CSR number.
REQ-009 EnqData  in  32  write data.
REQ-010 EnqMask  in  32  bit-write mask; all-ones for csrwr.
REQ-011 CommitValid  in  1  ROB retires its oldest instruction this cycle.
REQ-012 CommitRobId  in  ROBW  ROB index being retired.
REQ-013 Flush  in  1  pipeline flush (exception, ertn, mispredict).
REQ-014 CsrWAble  out  1  registered write strobe to the CSR file.
REQ-015 CsrWAddr / CsrWData / CsrWMask  out  14/32/32  registered write fields.
REQ-016 RdAddr  in  14  CSR number being read speculatively.
REQ-017 RdHit / RdData / RdMask  out  1/32/32  bypass from the youngest pending matching entry.
REQ-018 Count  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-019 SHALL hold entries in a circular FIFO with head (oldest) and tail pointers that wrap from DEPTH-1 to 0.
REQ-020 EnqReady SHALL equal (Count < DEPTH) AND NOT Flush; a full buffer SHALL NOT accept an entry even if a commit frees one in the same cycle.
REQ-021 On EnqValid AND EnqReady, the buffer SHALL write {RobId, Addr, Data, Mask} at tail, mark it valid, and advance tail.
REQ-022 A commit SHALL fire when CommitValid=1, the buffer is non-empty, and CommitRobId equals the head entry RobId; otherwise the commit SHALL be ignored with no state change.
REQ-023 On a fired commit in cycle N, CsrWAble SHALL be 1 in cycle N+1 with head entry Addr/Data/Mask, and head SHALL advance; CsrWAble SHALL be 0 in every other cycle.
REQ-024 At most one commit per cycle; latency from commit to CSR write is exactly one cycle.
REQ-025 Simultaneous enqueue and commit SHALL both take effect; Count unchanged.
REQ-026 On Flush, all entries SHALL be invalidated, head=tail=0, Count=0 next cycle; a commit firing in the same cycle SHALL still produce its CSR write in N+1 (commit is older than flush).
REQ-027 RdHit SHALL be combinational: 1 when any valid entry has Addr equal to RdAddr; RdData/RdMask SHALL come from the youngest such entry; 0 otherwise with RdData/RdMask = 0.
REQ-028 The same cycle's enqueue SHALL NOT be visible to RdHit (bypass sees registered entries only).
REQ-029 Count SHALL be tail-head distance with extra wrap bit distinguishing full from empty.

Reset
REQ-030 While Rest=0: all entries invalid, head=tail=0, Count=0, CsrWAble=0, CsrWAddr/CsrWData/CsrWMask=0, RdHit=0.
REQ-031 EnqReady SHALL be 1 in the first cycle after Rest deasserts with Flush=0.
REQ-032 Reset asserted mid-operation SHALL discard pending entries; no CSR write issued after reset.

Verification
REQ-033 Enq {Rob 5, Addr 0x30, Data 0xDEADBEEF, Mask 0xFFFFFFFF}; commit Rob 5 in cycle N -> CsrWAble=1, Addr 0x30, Data 0xDEADBEEF in N+1; Count 0.
REQ-034 Enq 4 entries Rob 1..4 -> Count=4, EnqReady=0; commit Rob 1 with EnqValid high -> enqueue refused, Count=3, then 5th enqueue accepted with tail wrap to 0.
REQ-035 Two pending writes to 0x31 (Data 0x11 then 0x22), RdAddr=0x31 -> RdHit=1, RdData=0x22; RdAddr=0x32 -> RdHit=0.
REQ-036 Commit Rob 7 while head holds Rob 6 -> no CsrWAble, Count unchanged.
REQ-037 Three entries pending, commit of head and Flush same cycle -> one CSR write in next cycle, Count=0, later commits ignored.
REQ-038 Assert Rest=0 with entries pending, release -> Count=0, CsrWAble=0, EnqReady=1.
